// File: rtl/dequeue_logic_pkg.sv
// dequeue_logic_pkg: definitions shared by the egress dequeue path and the
// enqueue side of the switch.
//   - FSM state encoding for dequeue_logic
//   - queue_number / pointer / length field widths
//   - front_update word layout {queue_number, next_ptr} and a packing helper
package dequeue_logic_pkg;

    localparam int PRIO_W  = 3;
    localparam int NUM_Q   = 1 << PRIO_W;
    localparam int QNUM_W  = 8;
    localparam int PTR_W   = 16;
    localparam int LEN_W   = 11;
    localparam int TIME_W  = 16;
    localparam int FRONT_W = QNUM_W + PTR_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_TX     = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;

    typedef struct packed {
        logic [QNUM_W-1:0] queue_number;
        logic [PTR_W-1:0]  next_ptr;
    } front_update_t;

    function automatic front_update_t pack_front(input logic [QNUM_W-1:0] qnum,
                                                 input logic [PTR_W-1:0]  ptr);
        front_update_t f;
        f.queue_number = qnum;
        f.next_ptr     = ptr;
        return f;
    endfunction

endpackage

// File: rtl/dequeue_logic_prio_select8.sv
// prio_select8: combinational highest-set-index picker.
//   req   [7:0]  candidate bits, bit 7 is the highest priority
//   idx   [2:0]  index of the highest set bit (0 when none set)
//   found        at least one bit set
module prio_select8
    import dequeue_logic_pkg::*;
(
    input  logic [NUM_Q-1:0]  req,
    output logic [PRIO_W-1:0] idx,
    output logic              found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // ascending scan: the last hit is the highest index
        for (int i = 0; i < NUM_Q; i++) begin
            if (req[i]) begin
                idx   = PRIO_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dequeue_logic.sv
// dequeue_logic: transmit-side scheduler for one egress port.
// Picks the highest-priority eligible queue under the current GCL entry,
// fetches its head descriptor, applies the guard-band check, hands the frame
// to the MAC and finally returns the front-pointer update and freed bytes.
//
// Ports
//   clk_in, rst_n           clock, synchronous active-low reset
//   dequeue_busy_n          1 = new frames may be started
//   queue_nonempty, gate_open, gate_time_left, gate_reload   queue / GCL status
//   desc_req, desc_queue    descriptor read request (1-cycle pulse)
//   desc_valid, desc_*      descriptor return
//   tx_start, tx_length, type_cur, tx_done                   MAC handshake
//   front_update_valid, front_update                         queue manager update
//   bm_release_valid, bm_release                             buffer manager release
//   dequeue_rdy             idle and allowed to start
//   desc_err                sticky descriptor timeout flag
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | choose highest eligible queue when allowed
// ST_REQ    | one-cycle descriptor request
// ST_WAIT   | wait for descriptor, bounded by DESC_TIMEOUT cycles
// ST_CHECK  | guard band: frame must fit in the remaining gate time
// ST_TX     | frame handed to MAC, wait for tx_done
// ST_UPDATE | one-cycle front pointer update and buffer release
module dequeue_logic
    import dequeue_logic_pkg::*;
#(
    parameter int PORT_W       = 5,
    parameter int PORT_ID      = 0,
    parameter int DESC_TIMEOUT = 16
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               dequeue_busy_n,
    input  logic [NUM_Q-1:0]   queue_nonempty,
    input  logic [NUM_Q-1:0]   gate_open,
    input  logic [TIME_W-1:0]  gate_time_left,
    input  logic               gate_reload,
    output logic               desc_req,
    output logic [QNUM_W-1:0]  desc_queue,
    input  logic               desc_valid,
    input  logic [LEN_W-1:0]   desc_frame_length,
    input  logic [PTR_W-1:0]   desc_next_ptr,
    input  logic               desc_type,
    output logic               tx_start,
    output logic [LEN_W-1:0]   tx_length,
    input  logic               tx_done,
    output logic               front_update_valid,
    output logic [FRONT_W-1:0] front_update,
    output logic               bm_release_valid,
    output logic [LEN_W-1:0]   bm_release,
    output logic               dequeue_rdy,
    output logic               type_cur,
    output logic               desc_err
);

    localparam int                TMO_W    = $clog2(DESC_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DESC_TIMEOUT - 1);
    localparam logic [PORT_W-1:0] PORT_SEL = PORT_W'(PORT_ID);

    logic [2:0]        state;
    logic [PRIO_W-1:0] prio_q;
    logic [LEN_W-1:0]  len_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              type_q;
    logic [NUM_Q-1:0]  blocked_mask;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tx_start_q;
    logic [LEN_W-1:0]  tx_length_q;
    logic              type_cur_q;
    logic              desc_err_q;

    logic [NUM_Q-1:0]  eligible;
    logic [PRIO_W-1:0] sel_idx;
    logic              sel_found;
    logic [QNUM_W-1:0] qnum;
    logic              fits;
    logic              upd_act;

    assign eligible = queue_nonempty & gate_open & ~blocked_mask;

    prio_select8 u_prio_select8 (
        .req   (eligible),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign qnum = QNUM_W'({PORT_SEL, prio_q});
    assign fits = (TIME_W'(len_q) <= gate_time_left);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            prio_q       <= '0;
            len_q        <= '0;
            ptr_q        <= '0;
            type_q       <= 1'b0;
            blocked_mask <= '0;
            tmo_cnt      <= '0;
            tx_start_q   <= 1'b0;
            tx_length_q  <= '0;
            type_cur_q   <= 1'b0;
            desc_err_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (gate_reload) begin
                blocked_mask <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (dequeue_busy_n && sel_found) begin
                        prio_q <= sel_idx;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (desc_valid) begin
                        len_q  <= desc_frame_length;
                        ptr_q  <= desc_next_ptr;
                        type_q <= desc_type;
                        state  <= ST_CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        desc_err_q <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (fits) begin
                        tx_start_q  <= 1'b1;
                        tx_length_q <= len_q;
                        type_cur_q  <= type_q;
                        state       <= ST_TX;
                    end else begin
                        // a new GCL entry arriving in the same cycle wins over the block
                        if (!gate_reload) begin
                            blocked_mask[prio_q] <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_TX: begin
                    if (tx_done) begin
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // strobes are qualified with rst_n so an asserted reset silences them at once
    assign upd_act            = rst_n && (state == ST_UPDATE);
    assign desc_req           = rst_n && (state == ST_REQ);
    assign desc_queue         = desc_req ? qnum : '0;
    assign tx_start           = tx_start_q;
    assign tx_length          = tx_length_q;
    assign type_cur           = type_cur_q;
    assign front_update_valid = upd_act;
    assign front_update       = upd_act ? pack_front(qnum, ptr_q) : '0;
    assign bm_release_valid   = upd_act;
    assign bm_release         = upd_act ? len_q : '0;
    assign dequeue_rdy        = rst_n && (state == ST_IDLE) && dequeue_busy_n;
    assign desc_err           = desc_err_q;

endmodule
